// File: rtl/sudoku_uart_rx.sv
// rtl/sudoku_uart_rx.sv - 8N1 UART receiver with small receive FIFO and sticky error flags
module sudoku_uart_rx #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable,
  input  logic [DIV_W-1:0] divisor,
  input  logic             ser_rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic             clear_err,
  output logic             overflow,
  output logic             frame_err,
  output logic             irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;

  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(4);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             frame_err_q, frame_err_d;
  logic             irq_q, irq_d;

  logic             tick;
  logic [DIV_W-1:0] div_eff;
  logic             push;
  logic             frame_set;
  logic             pop;
  logic             full;
  logic             accept;

  assign rx_data   = mem_q[rd_ptr_q];
  assign rx_valid  = (count_q != '0);
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign irq       = irq_q;

  // Two-flop synchroniser for the asynchronous pad
  always_comb begin
    rx_meta_d = ser_rx;
    rx_s_d    = rx_meta_q;
  end

  // Bit timer and frame FSM; disabling aborts any frame in progress
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    tick      = (cnt_q == '0);
    div_eff   = (divisor < MIN_DIV) ? MIN_DIV : divisor;

    if (state_q != S_IDLE) begin
      cnt_d = tick ? (div_q - DIV_ONE) : (cnt_q - DIV_ONE);
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          div_d   = div_eff;
          cnt_d   = div_eff >> 1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d   = S_IDLE;
      push      = 1'b0;
      frame_set = 1'b0;
    end
  end

  // FIFO bookkeeping; a same-cycle pop makes room for a push into a full FIFO
  always_comb begin
    pop      = rx_valid & rx_ready;
    full     = (count_q == FULL_CNT);
    accept   = push & (~full | pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    count_d = count_q + {{(CNT_W-1){1'b0}}, accept} - {{(CNT_W-1){1'b0}}, pop};
  end

  // Sticky flags (set beats clear) and registered interrupt
  always_comb begin
    overflow_d  = (overflow_q & ~clear_err) | (push & full & ~pop);
    frame_err_d = (frame_err_q & ~clear_err) | frame_set;
    irq_d       = rx_valid | overflow_q | frame_err_q;
  end

  // State registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= MIN_DIV;
      bit_q       <= '0;
      shift_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      irq_q       <= irq_d;
    end
  end

endmodule
